// File: rtl/regfile_pkg.sv
// Shared constants and types for the ARMv8 register file write side.
// XZR_IDX marks the hard-wired zero register.
package regfile_pkg;

  localparam int REG_WIDTH = 64;
  localparam int NUM_REGS  = 32;
  localparam int REG_AW    = 5;
  localparam int XZR_IDX   = 31;

  typedef logic [REG_AW-1:0]    reg_addr_t;
  typedef logic [REG_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_write_demux_decoder.sv
// Gate-level 5:32 one-hot decoder built from 2:4 and 3:8 blocks.
// Ports: en, addr[4:0] in; y[31:0] one-hot out (all zero when en=0).
module decoder2_4 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] y
);
  assign y[0] = en & ~a[1] & ~a[0];
  assign y[1] = en & ~a[1] &  a[0];
  assign y[2] = en &  a[1] & ~a[0];
  assign y[3] = en &  a[1] &  a[0];
endmodule

module decoder3_8 (
  input  logic       en,
  input  logic [2:0] a,
  output logic [7:0] y
);
  logic en_lo;
  logic en_hi;

  assign en_lo = en & ~a[2];
  assign en_hi = en &  a[2];

  decoder2_4 u_lo (.en(en_lo), .a(a[1:0]), .y(y[3:0]));
  decoder2_4 u_hi (.en(en_hi), .a(a[1:0]), .y(y[7:4]));
endmodule

module decoder5_32 (
  input  logic        en,
  input  logic [4:0]  addr,
  output logic [31:0] y
);
  logic [3:0] bank;

  decoder2_4 u_top (.en(en), .a(addr[4:3]), .y(bank));

  for (genvar i = 0; i < 4; i++) begin : g_bank
    decoder3_8 u_sub (
      .en(bank[i]),
      .a (addr[2:0]),
      .y (y[i*8 +: 8])
    );
  end
endmodule

// File: rtl/regfile_write_demux_mux.sv
// One-bit 32:1 read multiplexer used by the forwarding read ports.
// Ports: d[31:0], sel[4:0] in; y out. Present only with WB_BYPASS_EN.
`ifdef WB_BYPASS_EN
module mux32_1 (
  input  logic [31:0] d,
  input  logic [4:0]  sel,
  output logic        y
);
  assign y = d[sel];
endmodule
`endif

// File: rtl/regfile_write_demux.sv
// Register file write side: stage one write, decode, commit next edge; X31=XZR.
// Ports: clk, reset, wr_en/addr/data in; pend_vld/addr, wr_onehot, regs_out out.
// Macro WB_BYPASS_EN adds read ports rd_addr_a/b -> rd_data_a/b with forwarding.
module regfile_write_demux
  import regfile_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int NREGS = NUM_REGS,
  parameter int AW    = REG_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   pend_vld,
  output logic [AW-1:0]          pend_addr,
  output logic [NREGS-1:0]       wr_onehot,
  output logic [NREGS*WIDTH-1:0] regs_out
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0]          rd_addr_a,
  input  logic [AW-1:0]          rd_addr_b,
  output logic [WIDTH-1:0]       rd_data_a,
  output logic [WIDTH-1:0]       rd_data_b
`endif
);

  logic [WIDTH-1:0] stage_data;
  logic             commit_en;
  logic [WIDTH-1:0] regs [NREGS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
      stage_data <= '0;
    end else begin
      pend_vld <= wr_en;
      if (wr_en) begin
        pend_addr  <= wr_addr;
        stage_data <= wr_data;
      end
    end
  end

  // XZR mask: a staged write to 31 never enables the decoder.
  assign commit_en = pend_vld & (pend_addr != AW'(XZR_IDX));

  decoder5_32 u_dec (
    .en  (commit_en),
    .addr(pend_addr),
    .y   (wr_onehot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS - 1; k++)
        regs[k] <= '0;
    end else begin
      for (int k = 0; k < NREGS - 1; k++)
        if (wr_onehot[k])
          regs[k] <= stage_data;
    end
  end

  for (genvar k = 0; k < NREGS - 1; k++) begin : g_out
    assign regs_out[k*WIDTH +: WIDTH] = regs[k];
  end
  assign regs_out[XZR_IDX*WIDTH +: WIDTH] = '0;

`ifdef WB_BYPASS_EN
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;
  logic             fwd_a;
  logic             fwd_b;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NREGS-1:0] col;
    for (genvar k = 0; k < NREGS; k++) begin : g_col
      assign col[k] = regs_out[k*WIDTH + b];
    end
    mux32_1 u_mux_a (.d(col), .sel(rd_addr_a), .y(mux_a[b]));
    mux32_1 u_mux_b (.d(col), .sel(rd_addr_b), .y(mux_b[b]));
  end

  // Forward the staged write so readers see it one cycle before commit.
  assign fwd_a = pend_vld & (pend_addr == rd_addr_a)
               & (rd_addr_a != AW'(XZR_IDX));
  assign fwd_b = pend_vld & (pend_addr == rd_addr_b)
               & (rd_addr_b != AW'(XZR_IDX));

  assign rd_data_a = fwd_a ? stage_data : mux_a;
  assign rd_data_b = fwd_b ? stage_data : mux_b;
`endif

endmodule

// File: tb/tb_regfile_write_demux.sv
// Self-checking bench for regfile_write_demux.
// Staged writes are queued when driven and retired into a model at commit.
module tb_regfile_write_demux;
  import regfile_pkg::*;

  typedef struct {
    reg_addr_t a;
    reg_data_t d;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  wr_en;
  reg_addr_t             wr_addr;
  reg_data_t             wr_data;
  logic                  pend_vld;
  reg_addr_t             pend_addr;
  logic [31:0]           wr_onehot;
  logic [32*64-1:0]      regs_out;
`ifdef WB_BYPASS_EN
  reg_addr_t             rd_addr_a;
  reg_addr_t             rd_addr_b;
  reg_data_t             rd_data_a;
  reg_data_t             rd_data_b;
`endif

  int        total = 0;
  int        bad   = 0;
  reg_data_t model [32];
  wr_t       sb [$];

  regfile_write_demux dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pend_vld (pend_vld),
    .pend_addr(pend_addr),
    .wr_onehot(wr_onehot),
    .regs_out (regs_out)
`ifdef WB_BYPASS_EN
    ,
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_hot(input reg_addr_t a);
    exp_hot = (a == 5'd31) ? 32'h0 : (32'h1 << a);
  endfunction

`ifdef WB_BYPASS_EN
  function automatic reg_data_t exp_rd(input reg_addr_t a);
    if (a == 5'd31) exp_rd = '0;
    else if (sb.size() != 0 && sb[0].a == a) exp_rd = sb[0].d;
    else exp_rd = model[a];
  endfunction
`endif

  task automatic tick();
    logic      r;
    logic      e;
    reg_addr_t a;
    reg_data_t d;
    wr_t       w;
    r = reset;
    e = wr_en;
    a = wr_addr;
    d = wr_data;
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < 32; k++) model[k] = '0;
      sb.delete();
    end else begin
      if (sb.size() != 0) begin
        w = sb.pop_front();
        if (w.a != 5'd31) model[w.a] = w.d;
      end
      if (e) sb.push_back('{a, d});
    end
    chk("pend_vld", 64'(pend_vld), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("pend_addr", 64'(pend_addr), 64'(sb[0].a));
      chk("wr_onehot", 64'(wr_onehot), 64'(exp_hot(sb[0].a)));
    end else begin
      chk("wr_onehot", 64'(wr_onehot), 64'h0);
    end
    for (int k = 0; k < 32; k++)
      chk($sformatf("regs[%0d]", k), regs_out[k*64 +: 64], model[k]);
`ifdef WB_BYPASS_EN
    chk("rd_data_a", rd_data_a, exp_rd(rd_addr_a));
    chk("rd_data_b", rd_data_b, exp_rd(rd_addr_b));
`endif
  endtask

  task automatic wr(input reg_addr_t a, input reg_data_t d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = 64'h0;
    tick();
  endtask

  initial begin
    for (int k = 0; k < 32; k++) model[k] = '0;
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 64'hBAD0_BAD0_BAD0_BAD0;
`ifdef WB_BYPASS_EN
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd31;
`endif
    // reset for two cycles with a write presented during reset
    tick();
    tick();
    reset = 1'b0;
    idle();

    // single write
    wr(5'd5, 64'hDEAD_BEEF_0123_4567);
    chk("t2_onehot", 64'(wr_onehot), 64'h20);
    chk("t2_r5_before", regs_out[5*64 +: 64], 64'h0);
    idle();
    chk("t2_r5_after", regs_out[5*64 +: 64], 64'hDEAD_BEEF_0123_4567);

    // XZR
    wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_pend31", 64'(pend_addr), 64'd31);
    idle();
    chk("t3_r31", regs_out[31*64 +: 64], 64'h0);

    // back-to-back, same address twice
    wr(5'd1, 64'h11);
    wr(5'd1, 64'h22);
    wr(5'd2, 64'h33);
    idle();
    idle();
    chk("t4_r1", regs_out[1*64 +: 64], 64'h22);
    chk("t4_r2", regs_out[2*64 +: 64], 64'h33);

    // reset while a write is staged
    wr(5'd7, 64'h77);
    reset = 1'b1;
    wr_en = 1'b0;
    tick();
    chk("t5_r7", regs_out[7*64 +: 64], 64'h0);
    chk("t5_pend", 64'(pend_vld), 64'h0);
    reset = 1'b0;
    idle();

    // forwarding on the read ports
`ifdef WB_BYPASS_EN
    rd_addr_a = 5'd9;
    rd_addr_b = 5'd31;
`endif
    wr(5'd9, 64'hA5);
`ifdef WB_BYPASS_EN
    chk("t6_fwd_a", rd_data_a, 64'hA5);
    chk("t6_rd31", rd_data_b, 64'h0);
`endif
    chk("t6_r9_pre", regs_out[9*64 +: 64], 64'h0);
    idle();
    chk("t6_r9", regs_out[9*64 +: 64], 64'hA5);

    // random write mix with gaps
    for (int i = 0; i < 40; i++) begin
`ifdef WB_BYPASS_EN
      rd_addr_a = 5'($urandom_range(0, 31));
      rd_addr_b = 5'($urandom_range(0, 31));
`endif
      if ($urandom_range(0, 3) == 0) idle();
      else wr(5'($urandom_range(0, 31)),
              {$urandom, $urandom});
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
